// File: rtl/mixer_axil_regs.sv
// AXI4-Lite register file for the MIXER S00_AXI control port (four 32-bit regs).
// Optional: define MIXER_AXIL_DECERR_EN to answer slots 4-7 with SLVERR.
module mixer_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [3:0]                      reg_wr_pulse
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic             aw_held;
    logic [IDX_W-1:0] aw_idx;
    logic             w_held;
    logic [DW-1:0]    w_data;
    logic [SW-1:0]    w_strb;
    logic             bvalid;
    logic [1:0]       bresp;
    logic [3:0]       wr_pulse;

    logic             rvalid;
    logic [1:0]       rresp;
    logic [DW-1:0]    rdata;

    logic [DW-1:0]    regs [4];

    logic             aw_fire;
    logic             w_fire;
    logic             ar_fire;
    logic             commit;
    logic             aw_hit;
    logic             ar_hit;
    logic [IDX_W-1:0] ar_idx;
    logic [DW-1:0]    merged;
    logic [DW-1:0]    rd_mux;
    logic [1:0]       w_resp;
    logic [1:0]       r_resp;
    logic             unused_bits;

    assign S_AXI_AWREADY = !ARESET && !aw_held && !bvalid;
    assign S_AXI_WREADY  = !ARESET && !w_held && !bvalid;
    assign S_AXI_ARREADY = !ARESET && !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign reg_wr_pulse  = wr_pulse;
    assign reg_out       = {regs[3], regs[2], regs[1], regs[0]};

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit  = aw_held && w_held;

    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_hit = aw_idx < IDX_W'(4);
    assign ar_hit = ar_idx < IDX_W'(4);

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifdef MIXER_AXIL_DECERR_EN
    assign w_resp = aw_hit ? RESP_OKAY : RESP_SLVERR;
    assign r_resp = ar_hit ? RESP_OKAY : RESP_SLVERR;
`else
    assign w_resp = RESP_OKAY;
    assign r_resp = RESP_OKAY;
`endif

    // Byte-lane merge of the held write data into the addressed register.
    always_comb begin
        merged = regs[aw_idx[1:0]];
        for (int b = 0; b < SW; b++) begin
            if (w_strb[b]) begin
                merged[8*b +: 8] = w_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (ar_hit) begin
            rd_mux = regs[ar_idx[1:0]];
        end
    end

    // Write side: IDLE -> PARTIAL (one held) -> commit -> RESP until BREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= w_resp;
                if (aw_hit) begin
                    wr_pulse <= 4'd1 << aw_idx[1:0];
                end
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && aw_hit) begin
            regs[aw_idx[1:0]] <= merged;
        end
    end

    // Read side samples regs before any same-edge commit lands.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_fire) begin
            rvalid <= 1'b1;
            rresp  <= r_resp;
            rdata  <= rd_mux;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mixer_axil_regs.sv
// Self-checking bench for mixer_axil_regs: directed steps plus randomized
// accesses checked against an array-based register model.
module tb_mixer_axil_regs;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [4:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [4:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] model [8];

    mixer_axil_regs dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input int slot);
`ifdef MIXER_AXIL_DECERR_EN
        return (slot >= 4) ? 2'b10 : 2'b00;
`else
        return (slot >= 0) ? 2'b00 : 2'b11;
`endif
    endfunction

    function automatic logic [127:0] exp_regs();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic model_write(input int slot, input logic [31:0] d,
                               input logic [3:0] s);
        if (slot < 4) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[slot][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly,
                             input int w_dly, input int b_hold);
        int  cyc;
        int  slot;
        bit  aw_done;
        bit  w_done;
        bit  awf;
        bit  wf;
        logic [3:0] pulse;
        slot = int'(a[4:2]);
        aw_done = 0;
        w_done = 0;
        cyc = 0;
        S_AXI_AWADDR = a;
        S_AXI_WDATA = d;
        S_AXI_WSTRB = s;
        while (!(aw_done && w_done) && cyc < 100) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID = !w_done && (cyc >= w_dly);
            awf = S_AXI_AWVALID && S_AXI_AWREADY;
            wf = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (awf) aw_done = 1;
            if (wf) w_done = 1;
            cyc++;
        end
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 0;
        chk("wr_handshake", {127'd0, aw_done && w_done}, 128'd1);
        chk("bvalid_not_early", {127'd0, S_AXI_BVALID}, 128'd0);
        @(posedge ACLK); #1;
        pulse = (slot < 4) ? (4'd1 << slot) : 4'd0;
        model_write(slot, d, s);
        chk("bvalid_latency", {127'd0, S_AXI_BVALID}, 128'd1);
        chk("bresp", {126'd0, S_AXI_BRESP}, {126'd0, exp_resp(slot)});
        chk("wr_pulse", {124'd0, reg_wr_pulse}, {124'd0, pulse});
        chk("reg_out_wr", reg_out, exp_regs());
        for (int i = 0; i < b_hold; i++) begin
            S_AXI_AWVALID = 1;
            S_AXI_WVALID = 1;
            @(posedge ACLK); #1;
            chk("bvalid_hold", {127'd0, S_AXI_BVALID}, 128'd1);
            chk("awready_hold", {127'd0, S_AXI_AWREADY}, 128'd0);
            chk("wready_hold", {127'd0, S_AXI_WREADY}, 128'd0);
            chk("pulse_once", {124'd0, reg_wr_pulse}, 128'd0);
        end
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 0;
        S_AXI_BREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0;
        chk("bvalid_clear", {127'd0, S_AXI_BVALID}, 128'd0);
        chk("pulse_clear", {124'd0, reg_wr_pulse}, 128'd0);
        chk("reg_out_after_b", reg_out, exp_regs());
    endtask

    task automatic axi_read(input logic [4:0] a, input int r_hold);
        int  cyc;
        int  slot;
        bit  done;
        bit  fire;
        logic [31:0] exp;
        slot = int'(a[4:2]);
        exp = (slot < 4) ? model[slot] : 32'h0;
        done = 0;
        cyc = 0;
        S_AXI_ARADDR = a;
        S_AXI_ARVALID = 1;
        while (!done && cyc < 100) begin
            fire = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (fire) done = 1;
            cyc++;
        end
        S_AXI_ARVALID = 0;
        chk("rd_handshake", {127'd0, done}, 128'd1);
        chk("rvalid_latency", {127'd0, S_AXI_RVALID}, 128'd1);
        chk("rdata", {96'd0, S_AXI_RDATA}, {96'd0, exp});
        chk("rresp", {126'd0, S_AXI_RRESP}, {126'd0, exp_resp(slot)});
        for (int i = 0; i < r_hold; i++) begin
            @(posedge ACLK); #1;
            chk("rvalid_hold", {127'd0, S_AXI_RVALID}, 128'd1);
            chk("rdata_hold", {96'd0, S_AXI_RDATA}, {96'd0, exp});
        end
        S_AXI_RREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 0;
        chk("rvalid_clear", {127'd0, S_AXI_RVALID}, 128'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, {127'd0, S_AXI_AWREADY}, 128'd0);
        chk({tag, "_wready"}, {127'd0, S_AXI_WREADY}, 128'd0);
        chk({tag, "_arready"}, {127'd0, S_AXI_ARREADY}, 128'd0);
        chk({tag, "_bvalid"}, {127'd0, S_AXI_BVALID}, 128'd0);
        chk({tag, "_rvalid"}, {127'd0, S_AXI_RVALID}, 128'd0);
        chk({tag, "_resp"}, {124'd0, S_AXI_BRESP, S_AXI_RRESP}, 128'd0);
        chk({tag, "_rdata"}, {96'd0, S_AXI_RDATA}, 128'd0);
        chk({tag, "_reg_out"}, reg_out, 128'd0);
        chk({tag, "_pulse"}, {124'd0, reg_wr_pulse}, 128'd0);
    endtask

    initial begin
        int slot;
        S_AXI_AWADDR = '0;
        S_AXI_AWPROT = '0;
        S_AXI_AWVALID = 0;
        S_AXI_WDATA = '0;
        S_AXI_WSTRB = '0;
        S_AXI_WVALID = 0;
        S_AXI_BREADY = 0;
        S_AXI_ARADDR = '0;
        S_AXI_ARPROT = '0;
        S_AXI_ARVALID = 0;
        S_AXI_RREADY = 0;
        model_clear();
        ARESET = 0;
        #1 ARESET = 1;
        repeat (3) @(posedge ACLK);
        #1;
        chk_all_zero("reset");
        ARESET = 0;
        @(posedge ACLK); #1;
        chk("awready_idle", {127'd0, S_AXI_AWREADY}, 128'd1);

        // basic write/readback of all four registers
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), 0);
        end
        chk("reg_out_1234", reg_out,
            128'h00000004_00000003_00000002_00000001);

        // W leads AW by three cycles
        axi_write(5'h04, 32'hA5A5A5A5, 4'hF, 3, 0, 0);
        axi_read(5'h04, 1);

        // byte strobes
        axi_write(5'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_write(5'h00, 32'h12345678, 4'b0101, 0, 1, 0);
        chk("strobe_merge", {96'd0, reg_out[31:0]}, 128'hFF34FF78);
        axi_read(5'h00, 0);

        // zero strobe still pulses and responds
        axi_write(5'h08, 32'hCAFEBABE, 4'h0, 1, 0, 0);
        axi_read(5'h08, 0);

        // B back-pressure
        axi_write(5'h0C, 32'h11223344, 4'hF, 0, 0, 5);
        axi_read(5'h0C, 0);

        // unimplemented slots
        axi_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        axi_read(5'h14, 2);
        axi_read(5'h10, 0);

        // AR handshake on the commit edge returns the old value
        chk("awready_pre_same", {127'd0, S_AXI_AWREADY}, 128'd1);
        S_AXI_AWADDR = 5'h04;
        S_AXI_WDATA = 32'h0BADF00D;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1;
        S_AXI_WVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 0;
        S_AXI_ARADDR = 5'h04;
        S_AXI_ARVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 0;
        chk("same_edge_rvalid", {127'd0, S_AXI_RVALID}, 128'd1);
        chk("same_edge_old", {96'd0, S_AXI_RDATA}, {96'd0, model[1]});
        chk("same_edge_bvalid", {127'd0, S_AXI_BVALID}, 128'd1);
        model_write(1, 32'h0BADF00D, 4'hF);
        chk("same_edge_reg_out", reg_out, exp_regs());
        S_AXI_BREADY = 1;
        S_AXI_RREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0;
        S_AXI_RREADY = 0;
        axi_read(5'h04, 0);

        // reset while an AW is held
        S_AXI_AWADDR = 5'h08;
        S_AXI_AWVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0;
        #2 ARESET = 1;
        #1;
        model_clear();
        chk_all_zero("midreset");
        @(posedge ACLK); #1;
        ARESET = 0;
        @(posedge ACLK); #1;
        axi_write(5'h08, 32'h00000055, 4'hF, 0, 0, 0);
        axi_read(5'h08, 0);
        chk("midreset_reg2", {96'd0, reg_out[95:64]}, 128'h55);

        // randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            slot = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                axi_write(5'(4 * slot), $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)));
            end else begin
                axi_read(5'(4 * slot), int'($urandom_range(0, 2)));
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mixer_axil_regs.md
Name: mixer_axil_regs

Overview:
- AXI4-Lite slave (responder) register file for the MIXER IP's S00_AXI control port.
- Accepts single-beat writes and reads from the AXI4-Lite master and holds four 32-bit software registers.
- Exports the register contents and one-cycle write strobes to the mixer datapath.
- Sits between the AXI interconnect (or VIP master in simulation) and the mixer core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots, of which slots 0-3 are implemented.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- reg_out  out  128  {reg3,reg2,reg1,reg0} to the mixer core.
- reg_wr_pulse  out  4  one-cycle strobe per register on write commit.

Behaviour:
- Reset (ARESET high, asynchronous): all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, reg0..reg3 = 0, reg_wr_pulse 0, AW/W holding flags cleared.
- Reset asserted mid-transaction: the transaction is dropped and no register changes.
- Write address channel:
  - AWREADY = !aw_held && !BVALID.
  - On AWVALID&&AWREADY, latch AWADDR[4:2] and set aw_held.
- Write data channel:
  - WREADY = !w_held && !BVALID.
  - On WVALID&&WREADY, latch WDATA/WSTRB and set w_held.
- AW and W are accepted in any order, including the same cycle.
- Write commit occurs on the first cycle where aw_held && w_held:
  - Update the addressed register byte-wise per WSTRB.
  - Pulse reg_wr_pulse[idx] for 1 cycle.
  - Assert BVALID with BRESP=OKAY.
  - Clear both held flags.
  - Latency: BVALID rises 1 cycle after the later of the AW/W handshakes.
- BVALID holds until BREADY. AWREADY/WREADY stay low while BVALID=1, so at most one write is outstanding.
- Unimplemented slots 4-7: write is discarded, no pulse, BRESP per the optional feature.
- WSTRB=0: response is issued, the register is unchanged, and the pulse still fires.
- Read channel:
  - ARREADY = !RVALID.
  - On ARVALID&&ARREADY, register RDATA from the addressed slot (slots 4-7 return 0) and set RVALID on the next edge.
  - Latency: 1 cycle. RDATA/RVALID/RRESP hold until RREADY.
- Read and write paths are independent and may be active in the same cycle.
- Read of a register whose write commits on the same edge as the AR handshake returns the old value.
- No FSM beyond the held/valid flags; the write side has three states: IDLE, PARTIAL (one of AW/W held), RESP (BVALID).

Optional Feature:
- Macro: MIXER_AXIL_DECERR_EN.
- Defined: accesses to slots 4-7 return SLVERR (2'b10) on BRESP/RRESP; RDATA=0.
- Undefined: all accesses return OKAY; slots 4-7 read 0 and ignore writes.

Test Plan:
- Reset then write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C; read back -> RDATA 0x1..0x4, all RRESP=OKAY, reg_out=0x00000004_00000003_00000002_00000001.
- W presented 3 cycles before AW to 0x04 with data 0xA5A5A5A5 -> BVALID 1 cycle after the AW handshake; reg_wr_pulse=4'b0010 for exactly 1 cycle.
- Reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> reg0 reads 0xFF34FF78.
- Hold BREADY low for 5 cycles after a write -> BVALID stays high; AWREADY/WREADY stay low; a second AW is not accepted until the B handshake completes.
- Write 0xDEADBEEF to 0x10 and read 0x14 -> no register change, RDATA=0. Response is SLVERR with MIXER_AXIL_DECERR_EN defined, OKAY without it.
- Assert ARESET while aw_held=1 and BVALID=0 -> all outputs 0 asynchronously; after release a full write/read to 0x08 with 0x55 returns 0x55.
